// File: rtl/foreground_frame_stats.sv
// Per-frame foreground statistics: pixel count, bounding box and motion flag,
// accumulated from a raster is_foreground stream and handed off over valid/ready.
module foreground_frame_stats #(
    parameter  int FRAME_WIDTH      = 320,
    parameter  int FRAME_HEIGHT     = 240,
    parameter  int MOTION_THRESHOLD = 64,
    localparam int XW = $clog2(FRAME_WIDTH),
    localparam int YW = $clog2(FRAME_HEIGHT),
    localparam int CW = $clog2(FRAME_WIDTH*FRAME_HEIGHT+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pixel_valid,
    input  logic          start_of_frame,
    input  logic          is_foreground,
    output logic          stats_valid,
    input  logic          stats_ready,
    output logic [CW-1:0] fg_count,
    output logic [XW-1:0] min_x,
    output logic [XW-1:0] max_x,
    output logic [YW-1:0] min_y,
    output logic [YW-1:0] max_y,
    output logic          bbox_empty,
    output logic          motion_detected,
    output logic          frame_overrun,
    output logic          sync_error
);

    // state | meaning
    // IDLE  | waiting for pixel_valid && start_of_frame
    // ACCUM | mid-frame, each valid pixel advances (x,y)
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t        state_q;
    logic [XW-1:0] x_q, minx_q, out_minx_q, out_maxx_q, maxx_q;
    logic [YW-1:0] y_q, miny_q, out_miny_q, out_maxy_q, maxy_q;
    logic [CW-1:0] cnt_q, out_cnt_q;
    logic          seen_q, valid_q, empty_q, motion_q, overrun_q, sync_err_q;

    logic [XW-1:0] px, b_minx, minx_d, maxx_d;
    logic [YW-1:0] py, b_miny, miny_d, maxy_d;
    logic [CW-1:0] b_cnt, cnt_d;
    logic          b_seen, seen_d, take, last, frame_done, resync;

    always_comb begin
        take   = pixel_valid && (state_q == ACCUM || start_of_frame);
        // start_of_frame forces (0,0) and fresh accumulators for this pixel
        px     = start_of_frame ? '0 : x_q;
        py     = start_of_frame ? '0 : y_q;
        b_cnt  = start_of_frame ? '0 : cnt_q;
        b_seen = start_of_frame ? 1'b0 : seen_q;
        b_minx = minx_q;
        b_miny = miny_q;
        cnt_d  = b_cnt;
        seen_d = b_seen;
        minx_d = b_minx;
        maxx_d = maxx_q;
        miny_d = b_miny;
        maxy_d = maxy_q;
        if (is_foreground) begin
            cnt_d  = b_cnt + 1'b1;
            seen_d = 1'b1;
            minx_d = (!b_seen || px < b_minx)  ? px : b_minx;
            maxx_d = (!b_seen || px > maxx_q)  ? px : maxx_q;
            miny_d = (!b_seen || py < b_miny)  ? py : b_miny;
            maxy_d = (!b_seen || py > maxy_q)  ? py : maxy_q;
        end
        last       = (px == XW'(FRAME_WIDTH-1)) && (py == YW'(FRAME_HEIGHT-1));
        frame_done = take && last;
        resync     = pixel_valid && start_of_frame && (state_q == ACCUM) &&
                     (x_q != '0 || y_q != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            minx_q     <= '0;
            maxx_q     <= '0;
            miny_q     <= '0;
            maxy_q     <= '0;
            valid_q    <= 1'b0;
            out_cnt_q  <= '0;
            out_minx_q <= '0;
            out_maxx_q <= '0;
            out_miny_q <= '0;
            out_maxy_q <= '0;
            empty_q    <= 1'b0;
            motion_q   <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            overrun_q  <= 1'b0;
            sync_err_q <= resync;
            if (take) begin
                cnt_q  <= cnt_d;
                seen_q <= seen_d;
                minx_q <= minx_d;
                maxx_q <= maxx_d;
                miny_q <= miny_d;
                maxy_q <= maxy_d;
                if (last) begin
                    state_q <= IDLE;
                    x_q     <= '0;
                    y_q     <= '0;
                end else begin
                    state_q <= ACCUM;
                    if (px == XW'(FRAME_WIDTH-1)) begin
                        x_q <= '0;
                        y_q <= py + 1'b1;
                    end else begin
                        x_q <= px + 1'b1;
                        y_q <= py;
                    end
                end
            end
            if (frame_done) begin
                if (!valid_q || stats_ready) begin
                    valid_q    <= 1'b1;
                    out_cnt_q  <= cnt_d;
                    out_minx_q <= seen_d ? minx_d : '0;
                    out_maxx_q <= seen_d ? maxx_d : '0;
                    out_miny_q <= seen_d ? miny_d : '0;
                    out_maxy_q <= seen_d ? maxy_d : '0;
                    empty_q    <= !seen_d;
                    motion_q   <= (32'(cnt_d) >= MOTION_THRESHOLD);
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && stats_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign stats_valid     = valid_q;
    assign fg_count        = out_cnt_q;
    assign min_x           = out_minx_q;
    assign max_x           = out_maxx_q;
    assign min_y           = out_miny_q;
    assign max_y           = out_maxy_q;
    assign bbox_empty      = empty_q;
    assign motion_detected = motion_q;
    assign frame_overrun   = overrun_q;
    assign sync_error      = sync_err_q;

endmodule

// File: doc/foreground_frame_stats.md
Name: foreground_frame_stats

Overview:
Per-frame statistics stage directly downstream of the foreground detector. It consumes the raster-ordered per-pixel is_foreground stream and accumulates three results per frame: foreground pixel count, bounding box, and a motion flag. At end of frame it hands the results to the host-interface logic over a valid/ready handshake. The pixel stream has no backpressure, so accumulation of the next frame continues while a result waits to be consumed.

Parameters:
FRAME_WIDTH, 320, pixels per line.
FRAME_HEIGHT, 240, lines per frame.
MOTION_THRESHOLD, 64, minimum foreground count that sets motion_detected.
Derived widths (local):
- XW = $clog2(FRAME_WIDTH)
- YW = $clog2(FRAME_HEIGHT)
- CW = $clog2(FRAME_WIDTH*FRAME_HEIGHT+1)

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
pixel_valid  input  1  qualifies is_foreground and start_of_frame this cycle.
start_of_frame  input  1  with pixel_valid, marks pixel (0,0) of a frame.
is_foreground  input  1  foreground decision for the current pixel.
stats_valid  output  1  result registers hold an unconsumed frame result.
stats_ready  input  1  consumer accepts the result when stats_valid && stats_ready.
fg_count  output  CW  number of foreground pixels in the frame.
min_x  output  XW  bounding box left column.
max_x  output  XW  bounding box right column.
min_y  output  YW  bounding box top line.
max_y  output  YW  bounding box bottom line.
bbox_empty  output  1  frame contained no foreground pixels.
motion_detected  output  1  fg_count >= MOTION_THRESHOLD.
frame_overrun  output  1  one-cycle pulse when a completed result is dropped.
sync_error  output  1  one-cycle pulse when start_of_frame arrives mid-frame.

Behaviour:
Reset:
- All outputs are 0.
- State is IDLE; x/y counters and accumulators are cleared.

State machine (pixel side):
- IDLE: valid pixels without start_of_frame are ignored. pixel_valid && start_of_frame enters ACCUM, and that pixel is processed as (0,0).
- ACCUM: each valid pixel is processed at (x,y).
  - x increments each valid pixel and wraps to 0 after FRAME_WIDTH-1; y then increments.
  - The pixel at (FRAME_WIDTH-1, FRAME_HEIGHT-1) is the last pixel.
  - After the last pixel, return to IDLE and issue a frame-complete event.
- Cycles with pixel_valid=0 change nothing.

Accumulation per foreground pixel:
- count += 1.
- min_x = min(min_x, x); max_x = max(max_x, x); same for y.
- A seen flag is set.
- Accumulators reinitialise on the start_of_frame pixel (count 0, seen 0); that pixel then contributes normally.

Frame completion:
- The event includes the last pixel's own contribution.
- If stats_valid=0, or stats_valid && stats_ready in the same cycle: load the output registers and set stats_valid on the next edge. Latency is 1 cycle after the last pixel.
- Loaded values:
  - fg_count = count.
  - bbox_empty = !seen.
  - When empty, min/max are reported as 0.
  - motion_detected = (count >= MOTION_THRESHOLD), computed at full CW width.
- If stats_valid=1 and stats_ready=0: the new result is dropped, outputs keep the old result, and frame_overrun pulses for 1 cycle.

Handshake:
- stats_valid falls the cycle after stats_valid && stats_ready, unless a new result loads in that same cycle (then it stays high with new data).
- Output values are stable while stats_valid=1.

Resynchronisation:
- start_of_frame with pixel_valid in ACCUM at any position other than (0,0) discards the partial frame and pulses sync_error.
- The frame restarts at (0,0) with that pixel; no result is produced for the discarded frame.

Reset mid-operation:
- Immediate return to the reset state.
- Any pending unconsumed result is lost and stats_valid=0.

Test Plan:
1. Params W=4, H=3, T=2. Reset, then a frame with foreground at (1,0) and (2,2) -> one cycle after the last pixel: stats_valid=1, fg_count=2, min_x=1, max_x=2, min_y=0, max_y=2, motion_detected=1, bbox_empty=0.
2. All-background frame -> fg_count=0, bbox_empty=1, min/max=0, motion_detected=0; stats_ready=1 -> stats_valid=0 next cycle.
3. Single foreground pixel at (3,2), the last pixel, with gaps of pixel_valid=0 inside the frame -> fg_count=1, box (3,3,2,2), motion_detected=0; gaps have no effect.
4. Two back-to-back frames with stats_ready held 0 -> second completion pulses frame_overrun, outputs keep frame-1 values; stats_ready=1 in the cycle of the second frame's last pixel instead -> frame-2 values load and stats_valid stays 1.
5. start_of_frame asserted at (2,1) -> sync_error pulse, restart from (0,0); the following complete frame reports only its own pixels.
6. reset asserted mid-frame and while stats_valid=1 -> all outputs 0 next cycle; pixels without start_of_frame are ignored until the next start_of_frame.
